// File: rtl/adc_init_seq.sv
`timescale 1ns/1ps
// adc_init_seq: power-up sequencer for a bank of ADCs.
// Pulses ADC reset, waits to settle, then configures each enabled ADC with retries.
module adc_init_seq #(
  parameter int NADC         = 6,
  parameter int RST_TICKS    = 2,
  parameter int SETTLE_TICKS = 4,
  parameter int TIME_OUT     = 5,
  parameter int MAX_RETRY    = 2
) (
  input  logic            CLK,
  input  logic            RST_B,
  input  logic            TICK,
  input  logic            START,
  input  logic [NADC-1:0] ADC_MASK,
  input  logic            CFG_DONE,
  output logic            ADC_RST,
  output logic            CFG_REQ,
  output logic [2:0]      CFG_SEL,
  output logic            RUN,
  output logic            FAIL,
  output logic [NADC-1:0] FAIL_MAP
);

  typedef enum logic [2:0] {
    IDLE, RST_ADC, SETTLE, SCAN, REQ, WAIT, DONE
  } state_t;

  state_t          state, state_nxt;
  logic [11:0]     cnt, cnt_nxt;
  logic [3:0]      idx, idx_nxt;
  logic [7:0]      retry, retry_nxt;
  logic [NADC-1:0] map, map_nxt;
  logic [12:0]     cnt_inc;
  logic            mask_bit;
  logic            tick_rst, tick_set, tick_to;
  logic            restart;

  assign cnt_inc  = {1'b0, cnt} + 13'd1;
  assign tick_rst = TICK && (cnt_inc == 13'(RST_TICKS));
  assign tick_set = TICK && (cnt_inc == 13'(SETTLE_TICKS));
  assign tick_to  = TICK && (cnt_inc == 13'(TIME_OUT));
  assign restart  = START && (state != IDLE);

  // Enable bit of the ADC currently indexed (0 once past the last ADC).
  always_comb begin
    mask_bit = 1'b0;
    for (int i = 0; i < NADC; i++)
      if (idx == 4'(i)) mask_bit = ADC_MASK[i];
  end

  // Next-state, index/retry bookkeeping and saturating tick counter.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    retry_nxt = retry;
    map_nxt   = map;
    cnt_nxt   = cnt;
    if (TICK && cnt != 12'hFFF)
      cnt_nxt = cnt + 12'd1;
    case (state)
      IDLE:    state_nxt = RST_ADC;
      RST_ADC: if (tick_rst) state_nxt = SETTLE;
      SETTLE: begin
        if (tick_set) begin
          state_nxt = SCAN;
          idx_nxt   = 4'd0;
          retry_nxt = 8'd0;
        end
      end
      SCAN: begin
        if (idx == 4'(NADC))
          state_nxt = DONE;
        else if (!mask_bit)
          idx_nxt = idx + 4'd1;
        else
          state_nxt = REQ;
      end
      REQ:  state_nxt = WAIT;
      WAIT: begin
        if (CFG_DONE) begin
          idx_nxt   = idx + 4'd1;
          retry_nxt = 8'd0;
          state_nxt = SCAN;
        end else if (tick_to) begin
          state_nxt = SCAN;
          if (retry < 8'(MAX_RETRY)) begin
            retry_nxt = retry + 8'd1;
          end else begin
            for (int i = 0; i < NADC; i++)
              if (idx == 4'(i)) map_nxt[i] = 1'b1;
            idx_nxt   = idx + 4'd1;
            retry_nxt = 8'd0;
          end
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (restart) begin
      state_nxt = RST_ADC;
      idx_nxt   = 4'd0;
      retry_nxt = 8'd0;
      map_nxt   = '0;
    end
    if (restart || state_nxt != state)
      cnt_nxt = 12'd0;
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state <= IDLE;
      cnt   <= 12'd0;
      idx   <= 4'd0;
      retry <= 8'd0;
      map   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      retry <= retry_nxt;
      map   <= map_nxt;
    end
  end

  assign ADC_RST  = (state == IDLE) || (state == RST_ADC);
  assign CFG_REQ  = (state == REQ) || (state == WAIT);
  assign CFG_SEL  = idx[2:0];
  assign RUN      = (state == DONE) && (map == '0);
  assign FAIL     = (state == DONE) && (map != '0);
  assign FAIL_MAP = map;

endmodule

// File: tb/tb_adc_init_seq.sv
`timescale 1ns/1ps
// tb_adc_init_seq: table-driven bench for the ADC init sequencer.
// A responder models the config engine; a monitor tallies requests per ADC.
module tb_adc_init_seq;

  logic       CLK = 1'b0;
  logic       RST_B = 1'b0;
  logic       TICK = 1'b0;
  logic       START = 1'b0;
  logic [5:0] ADC_MASK = '0;
  logic       CFG_DONE = 1'b0;
  logic       ADC_RST, CFG_REQ, RUN, FAIL;
  logic [2:0] CFG_SEL;
  logic [5:0] FAIL_MAP;

  adc_init_seq #(
    .NADC(6), .RST_TICKS(2), .SETTLE_TICKS(4),
    .TIME_OUT(5), .MAX_RETRY(2)
  ) dut (
    .CLK(CLK), .RST_B(RST_B), .TICK(TICK),
    .START(START), .ADC_MASK(ADC_MASK),
    .CFG_DONE(CFG_DONE), .ADC_RST(ADC_RST),
    .CFG_REQ(CFG_REQ), .CFG_SEL(CFG_SEL),
    .RUN(RUN), .FAIL(FAIL), .FAIL_MAP(FAIL_MAP)
  );

  always #5 CLK = ~CLK;

  // ans[i]: attempt on which ADC i answers; 0 = never, 7 = on the timeout tick
  typedef struct packed {
    logic [5:0]      mask;
    logic [5:0][2:0] ans;
    logic [5:0][1:0] ecnt;
    logic [5:0]      emap;
    logic            erun;
    logic            efail;
  } vec_t;

  vec_t vt [8];

  int errs = 0;
  int checks = 0;

  logic [5:0][2:0] ans = '0;
  int     rc [6];
  int     att [6];
  int     proto = 0, rst_tk = 0, set_tk = 0;
  int     last_sel = 0, wt = 0, ph = 0, a = 0;
  bit     anyreq = 0, prev_req = 0, prev_done = 0;
  bit     dseen = 0, late = 0, abort_ok = 0, tk = 0, dn = 0;
  logic [2:0] prev_sel = '0;
  longint cyc = 0, done_at = -1;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr_mon();
    for (int k = 0; k < 6; k++) begin
      rc[k] = 0;
      att[k] = 0;
    end
    proto = 0; rst_tk = 0; set_tk = 0;
    anyreq = 0; last_sel = 0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge CLK);
      if (RUN || FAIL) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic wait_req(input int sel, output bit ok);
    ok = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge CLK);
      if (CFG_REQ && CFG_SEL == 3'(sel)) begin
        ok = 1;
        return;
      end
    end
  endtask

  // Tick generator, config-engine responder and protocol monitor.
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (!RST_B) begin
      ph = 0;
      tk = 0;
    end else begin
      tk = (ph == 3);
      ph = (ph + 1) % 4;
    end
    dn = 0;
    if (CFG_REQ && !prev_req && CFG_SEL < 3'd6) begin
      rc[CFG_SEL]++;
      att[CFG_SEL]++;
      if (int'(CFG_SEL) < last_sel) proto++;
      last_sel = int'(CFG_SEL);
      anyreq = 1;
      wt = 0;
      dseen = 0;
      late = 0;
      a = int'(ans[CFG_SEL]);
      if (a == 7 && att[CFG_SEL] == 1) late = 1;
      else if (a != 0 && att[CFG_SEL] == a) done_at = cyc + 2;
    end
    if (CFG_REQ && prev_req) begin
      if (CFG_SEL != prev_sel) proto++;
      if (late && tk && wt == 4) dn = 1;
      if (tk) wt++;
    end
    if (cyc == done_at) dn = 1;
    if (!CFG_REQ && prev_req && !dseen && !abort_ok && wt != 5)
      proto++;
    if (CFG_REQ && prev_req && prev_done) proto++;
    if (CFG_REQ && dn) dseen = 1;
    if (RUN && FAIL) proto++;
    if (RST_B && tk && ADC_RST) rst_tk++;
    if (RST_B && tk && !ADC_RST && !CFG_REQ && !anyreq && !RUN && !FAIL)
      set_tk++;
    TICK = tk;
    CFG_DONE = dn;
    prev_req = CFG_REQ;
    prev_sel = CFG_SEL;
    prev_done = dn;
  end

  task automatic run_vec(input int i);
    bit ok;
    ADC_MASK = vt[i].mask;
    ans = vt[i].ans;
    clr_mon();
    if (i == 0) begin
      repeat (3) @(negedge CLK);
      chk("rst ADC_RST", int'(ADC_RST), 1);
      chk("rst CFG_REQ", int'(CFG_REQ), 0);
      chk("rst CFG_SEL", int'(CFG_SEL), 0);
      chk("rst RUN", int'(RUN), 0);
      chk("rst FAIL", int'(FAIL), 0);
      chk("rst FAIL_MAP", int'(FAIL_MAP), 0);
      RST_B = 1'b1;
    end else begin
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
    end
    wait_done(ok);
    chk($sformatf("v%0d reached done", i), int'(ok), 1);
    repeat (3) @(negedge CLK);
    chk($sformatf("v%0d RUN", i), int'(RUN), int'(vt[i].erun));
    chk($sformatf("v%0d FAIL", i), int'(FAIL), int'(vt[i].efail));
    chk($sformatf("v%0d FAIL_MAP", i), int'(FAIL_MAP), int'(vt[i].emap));
    for (int k = 0; k < 6; k++)
      chk($sformatf("v%0d requests adc%0d", i, k), rc[k], int'(vt[i].ecnt[k]));
    chk($sformatf("v%0d protocol errors", i), proto, 0);
    chk($sformatf("v%0d reset ticks", i), rst_tk, 2);
    if (vt[i].mask[0])
      chk($sformatf("v%0d settle ticks", i), set_tk, 4);
  endtask

  initial begin
    bit ok;
    vt[0] = '{mask: 6'h3F, ans: {6{3'd1}}, ecnt: {6{2'd1}},
              emap: 6'h00, erun: 1'b1, efail: 1'b0};
    vt[1] = '{mask: 6'h25, ans: {6{3'd1}},
              ecnt: {2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1},
              emap: 6'h00, erun: 1'b1, efail: 1'b0};
    vt[2] = '{mask: 6'h3F,
              ans: {3'd1, 3'd1, 3'd0, 3'd1, 3'd1, 3'd1},
              ecnt: {2'd1, 2'd1, 2'd3, 2'd1, 2'd1, 2'd1},
              emap: 6'h08, erun: 1'b0, efail: 1'b1};
    vt[3] = '{mask: 6'h3F,
              ans: {3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd1},
              ecnt: {2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1},
              emap: 6'h00, erun: 1'b1, efail: 1'b0};
    vt[4] = '{mask: 6'h00, ans: {6{3'd1}}, ecnt: {6{2'd0}},
              emap: 6'h00, erun: 1'b1, efail: 1'b0};
    vt[5] = '{mask: 6'h3F,
              ans: {3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0},
              ecnt: {2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3},
              emap: 6'h21, erun: 1'b0, efail: 1'b1};
    vt[6] = '{mask: 6'h12,
              ans: {3'd1, 3'd3, 3'd1, 3'd1, 3'd1, 3'd1},
              ecnt: {2'd0, 2'd3, 2'd0, 2'd0, 2'd1, 2'd0},
              emap: 6'h00, erun: 1'b1, efail: 1'b0};
    vt[7] = '{mask: 6'h3F,
              ans: {3'd1, 3'd1, 3'd1, 3'd7, 3'd1, 3'd1},
              ecnt: {6{2'd1}},
              emap: 6'h00, erun: 1'b1, efail: 1'b0};

    for (int i = 0; i < 8; i++)
      run_vec(i);

    // Abort during WAIT for ADC 2 after ADC 0 has already failed.
    ADC_MASK = 6'h3F;
    ans = {3'd1, 3'd1, 3'd1, 3'd0, 3'd1, 3'd0};
    clr_mon();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_req(2, ok);
    chk("abort reached adc2", int'(ok), 1);
    repeat (3) @(negedge CLK);
    chk("abort map before", int'(FAIL_MAP), 1);
    abort_ok = 1;
    ans = {6{3'd1}};
    clr_mon();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("abort CFG_REQ", int'(CFG_REQ), 0);
    chk("abort ADC_RST", int'(ADC_RST), 1);
    chk("abort FAIL_MAP", int'(FAIL_MAP), 0);
    repeat (2) @(negedge CLK);
    abort_ok = 0;
    wait_done(ok);
    chk("abort rerun done", int'(ok), 1);
    chk("abort rerun RUN", int'(RUN), 1);
    for (int k = 0; k < 6; k++)
      chk($sformatf("abort rerun adc%0d", k), rc[k], 1);
    chk("abort protocol errors", proto, 0);
    chk("abort reset ticks", rst_tk, 2);

    // Asynchronous reset in the middle of a sequence.
    ans = {3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    clr_mon();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_req(1, ok);
    chk("areset reached adc1", int'(ok), 1);
    chk("areset map before", int'(FAIL_MAP), 1);
    abort_ok = 1;
    RST_B = 1'b0;
    #1;
    chk("areset ADC_RST", int'(ADC_RST), 1);
    chk("areset CFG_REQ", int'(CFG_REQ), 0);
    chk("areset CFG_SEL", int'(CFG_SEL), 0);
    chk("areset FAIL_MAP", int'(FAIL_MAP), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/adc_init_seq.md
ADC_INIT_SEQ -- requirements
Module: adc_init_seq

Interface
REQ-001 Parameter NADC, default 6: number of ADCs sequenced; SHALL be 1..8.
REQ-002 Parameter RST_TICKS, default 2: ADC reset pulse length, in TICK periods.
REQ-003 Parameter SETTLE_TICKS, default 4: post-reset wait, in TICK periods.
REQ-004 Parameter TIME_OUT, default 5: per-attempt CFG_DONE timeout, in TICK periods.
REQ-005 Parameter MAX_RETRY, default 2: extra attempts per ADC after the first timeout.
REQ-006 CLK  in  1  system clock; the only clock; all logic on rising edge.
REQ-007 RST_B  in  1  asynchronous active-low reset.
REQ-008 TICK  in  1  one-CLK-wide slow-time strobe (100 kHz), synchronous to CLK.
REQ-009 START  in  1  one-cycle pulse; restarts the full init sequence.
REQ-010 ADC_MASK  in  NADC  per-ADC enable; 0 = skip that ADC.
REQ-011 CFG_DONE  in  1  configuration engine completion, sampled only in WAIT.
REQ-012 ADC_RST  out  1  active-high reset to all ADCs.
REQ-013 CFG_REQ  out  1  level request to the serial configuration engine.
REQ-014 CFG_SEL  out  3  index of ADC being configured; stable while CFG_REQ=1.
REQ-015 RUN  out  1  init finished, no failures.
REQ-016 FAIL  out  1  init finished, at least one ADC failed.
REQ-017 FAIL_MAP  out  NADC  bit i = ADC i exhausted its retries.

Function
REQ-018 The sequencer SHALL be a Moore FSM with states RST_ADC, SETTLE, SCAN, REQ, WAIT, DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-019 The first CLK edge after RST_B deasserts SHALL move IDLE (reset state) to RST_ADC.
REQ-020 RST_ADC: ADC_RST=1; a 12-bit tick counter, cleared on state entry, SHALL increment on TICK; on the TICK that makes the count equal RST_TICKS, go to SETTLE.
REQ-021 SETTLE: same counting rule with SETTLE_TICKS; then go to SCAN with index=0 and retry count=0.
REQ-022 SCAN: if index=NADC, go to DONE; else if ADC_MASK[index]=0, increment index and stay (one index per cycle); else go to REQ.
REQ-023 REQ: CFG_REQ=1, CFG_SEL=index, tick counter cleared; next cycle go to WAIT.
REQ-024 WAIT: CFG_REQ=1; CFG_DONE=1 SHALL cause index+1, retry count cleared, next state SCAN, with CFG_REQ low in that next cycle.
REQ-025 WAIT: on the TICK that makes the count equal TIME_OUT with CFG_DONE=0, a timeout occurs; if retry count < MAX_RETRY, increment it and go to SCAN (same index, CFG_REQ low at least one cycle, then re-request).
REQ-026 If a timeout occurs when retry count = MAX_RETRY, FAIL_MAP[index] SHALL set, index increment, retry count clear, next state SCAN.
REQ-027 CFG_DONE and a timeout in the same cycle SHALL count as success.
REQ-028 DONE: RUN=1 if FAIL_MAP is all zero; otherwise FAIL=1; RUN and FAIL SHALL never both be 1; state holds until START.
REQ-029 START in any state other than IDLE SHALL abort the current step: clear FAIL_MAP, RUN, FAIL, index, retry count and the tick counter, drop CFG_REQ, and enter RST_ADC on the next edge.
REQ-030 ADC_MASK SHALL be sampled only in SCAN; changes during WAIT do not affect the ADC in progress.
REQ-031 The tick counter SHALL saturate at 4095 and never wrap.
REQ-032 With ADC_MASK all zero, the sequencer SHALL pass straight from SCAN to DONE with RUN=1.
REQ-033 CFG_DONE outside WAIT SHALL be ignored.

Reset
REQ-034 While RST_B=0: state IDLE, ADC_RST=1, CFG_REQ=0, CFG_SEL=0, RUN=0, FAIL=0, FAIL_MAP=0, and all counters 0.
REQ-035 Reset assertion mid-sequence SHALL take effect asynchronously, without waiting for a clock edge.

Verification
REQ-036 Power-up, mask=6'h3F, CFG_DONE two cycles after each CFG_REQ rise -> ADC_RST high for 2 TICKs, then 4 TICKs settle, then 6 requests with CFG_SEL=0..5, then RUN=1, FAIL_MAP=0.
REQ-037 Mask=6'h25 -> requests only for CFG_SEL=0,2,5, then RUN=1.
REQ-038 ADC 3 never answers -> CFG_SEL=3 requested 3 times, each ending 5 TICKs after entering WAIT; FAIL_MAP=6'h08, FAIL=1, RUN=0.
REQ-039 ADC 1 answers only on its second attempt -> 2 requests with CFG_SEL=1, then RUN=1, FAIL_MAP=0.
REQ-040 START pulse during WAIT for ADC 2 -> CFG_REQ=0 next cycle, ADC_RST=1, FAIL_MAP cleared, full sequence reruns from ADC 0.
REQ-041 CFG_DONE on the same cycle as the timeout TICK -> success path taken; FAIL_MAP bit stays 0.
